seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Display-side reader for the 4-digit scanned 7-segment bus (AN/SEGMENT).
//  Samples the multiplexed anode and segment lines and decodes each segment pattern back to a hex nibble.
//  Reassembles the full 16-bit word with its point/blank flags and publishes it once per complete scan frame.
//  Used as an in-system self-check and bench monitor for the scoreboard display path.
// PARAMETERS
//  SETTLE  4  consecutive cycles AN+SEGMENT must be unchanged before a digit is sampled (>=1)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous reset, active-high
//  an           in   4   digit selects, active-low; one-hot-low = digit selected
//  segment      in   8   active-low; [0]=a..[6]=g, [7]=p (decimal point)
//  hexs         out  16  decoded digits; [3:0]=digit0 (an[0]) .. [15:12]=digit3
//  point        out  4   1 = decimal point lit on that digit
//  les          out  4   1 = digit blank (segment[6:0]==7'h7F)
//  bad          out  4   1 = pattern not in decode table and not blank
//  frame_valid  out  1   1-cycle pulse when hexs/point/les/bad update
//  err          out  1   OR of bad[] of last committed frame
// BEHAVIOUR
//  - Reset: all outputs 0; seen mask 0; state IDLE; sync flops and stable counter cleared.
//  - an/segment pass through a 2-FF synchroniser (12 bits each stage); all logic below uses synced copies.
//  - Valid select: exactly one an bit low. 4'b1111 or any multi-low value = no select.
//  - FSM:
//    IDLE   : no valid select; cnt=0. Valid select -> SETTLE (cnt=1).
//    SETTLE : if {an,segment} differs from previous cycle: valid -> restart cnt=1, invalid -> IDLE.
//             else cnt++; when cnt==SETTLE sample digit -> HOLD.
//    HOLD   : one sample per dwell; any change of {an,segment} -> SETTLE (valid) or IDLE.
//  - Sample: nibble/point/les/bad for selected digit written to staging regs; seen[d]<=1.
//    Re-sampling a digit already seen in this frame overwrites its staging value.
//  - Decode (active-low g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E. Blank 7F -> nibble 0, les=1.
//    Other -> nibble 0, bad=1. point = ~segment[7] regardless of pattern.
//  - Commit: cycle after the sample that makes seen==4'hF, staging copied to outputs atomically;
//    frame_valid=1 for that cycle; seen<=0. Outputs hold between commits.
//  - Latency, first edge of stable digit -> sample: 2 (sync) + SETTLE cycles.
//  - Digit order irrelevant; a frame needs all four digits seen at least once.
//  - Invalid select mid-frame: no sample; seen mask retained (frame continues).
//  - Reset mid-frame: staging, seen and outputs all cleared; no frame_valid.
//  - Sample and commit in same cycle impossible (commit strictly follows a sample).
//  - SETTLE counter width $clog2(SETTLE+1); saturates, never wraps in HOLD.
// STRUCTURE
//  - seg7_pkg: decode-table localparams (16 active-low patterns), SEG_BLANK=7'h7F,
//    FSM state encodings (IDLE/SETTLE/HOLD).
//  - Sub-module seg7_decode: combinational pattern[6:0] -> {nibble[3:0], blank, bad};
//    inverse of the MC14495 table, reusable by benches.
//  - Top: synchroniser, FSM + stable counter, staging regs, seen mask, commit logic.
// TESTING
//  1 Reset: rst=1 for 3 cycles with random an/segment -> all outputs 0, no frame_valid.
//  2 Clean scan (SETTLE=4, dwell 8 cyc/digit) of 0x1A2F, points on digit2:
//    ~seg d0=0E, d1=24, d2=08 w/ p, d3=79 -> hexs=16'h1A2F, point=4'b0100,
//    les=0, bad=0, one frame_valid per full scan.
//  3 Glitch: 3-cycle segment change mid-dwell (< SETTLE) -> no sample of glitch value;
//    hexs unchanged.
//  4 Blank + bad: d3=7F, d1=7E -> les=4'b1000, bad=4'b0010, nibbles 0, err=1.
//  5 Idle gap: an=1111 for 50 cycles after 2 digits, then remaining 2 ->
//    single frame_valid, correct hexs.
//  6 rst pulse after 3 digits seen -> outputs 0; a full new scan is needed before frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: decode table, blank pattern and FSM states for the scanned 7-segment reader
package seg7_pkg;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment pattern back to hex nibble, with blank/bad flags
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);
    logic hit;
    always_comb begin
        nibble = '0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                nibble = 4'(i);
                hit = 1'b1;
            end
        end
        blank = pattern == SEG_BLANK;
        bad = !hit && !blank;
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples the multiplexed an/segment bus once per stable dwell
// and publishes the reassembled 4-digit word after every digit has been seen.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  segment,
    output logic [15:0] hexs,
    output logic [3:0]  point,
    output logic [3:0]  les,
    output logic [3:0]  bad,
    output logic        frame_valid,
    output logic        err
);
    localparam int CW = $clog2(SETTLE + 1);
    logic [11:0] s1, s2, prev;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] sel, seen;
    logic valid, chg, sample;
    logic [3:0] nib;
    logic blank, inv;
    logic [15:0] hex_st;
    logic [3:0] pt_st, les_st, bad_st;
    assign sel = ~s2[11:8];
    assign valid = $onehot(sel);
    assign chg = s2 != prev;
    seg7_decode u_dec (
        .pattern(s2[6:0]),
        .nibble(nib),
        .blank(blank),
        .bad(inv)
    );
    // Any change restarts the dwell; a sample is taken once per stable dwell.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sample = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    state_n = S_SETTLE;
                    cnt_n = CW'(1);
                end
            end
            default: begin
                if (chg) begin
                    state_n = valid ? S_SETTLE : S_IDLE;
                    cnt_n = valid ? CW'(1) : '0;
                end else if (state == S_SETTLE) begin
                    cnt_n = (cnt == CW'(SETTLE)) ? cnt : cnt + CW'(1);
                    if (cnt_n == CW'(SETTLE)) begin
                        sample = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
            state <= S_IDLE;
            cnt <= '0;
            seen <= '0;
            hex_st <= '0;
            pt_st <= '0;
            les_st <= '0;
            bad_st <= '0;
            hexs <= '0;
            point <= '0;
            les <= '0;
            bad <= '0;
            frame_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            s1 <= {an, segment};
            s2 <= s1;
            prev <= s2;
            state <= state_n;
            cnt <= cnt_n;
            for (int i = 0; i < 4; i++) begin
                if (sample && sel[i]) begin
                    hex_st[i*4 +: 4] <= nib;
                    pt_st[i] <= ~s2[7];
                    les_st[i] <= blank;
                    bad_st[i] <= inv;
                end
            end
            // Commit can never coincide with a sample: the completing sample moves the FSM to HOLD.
            seen <= (seen == 4'hF) ? 4'h0 : sample ? (seen | sel) : seen;
            frame_valid <= seen == 4'hF;
            if (seen == 4'hF) begin
                hexs <= hex_st;
                point <= pt_st;
                les <= les_st;
                bad <= bad_st;
                err <= |bad_st;
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random scans checked against a dwell-level reference model
module tb_seg7_capture;
    localparam int SETTLE = 4;
    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] an = 4'hF;
    logic [7:0] segment = 8'hFF;
    logic [15:0] hexs;
    logic [3:0] point, les, bad;
    logic frame_valid, err;
    int checks = 0;
    int errors = 0;
    logic [28:0] obs_q[$];
    logic [28:0] exp_q[$];
    logic [28:0] last_exp;
    logic [3:0] m_hex [4];
    logic [3:0] m_pt, m_les, m_bad, m_seen;
    logic [11:0] m_prev;
    int m_run;

    seg7_capture #(.SETTLE(SETTLE)) dut (
        .clk(clk),
        .rst(rst),
        .an(an),
        .segment(segment),
        .hexs(hexs),
        .point(point),
        .les(les),
        .bad(bad),
        .frame_valid(frame_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) obs_q.push_back({err, bad, les, point, hexs});

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [5:0] ref_dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (p == TBL[i]) return {4'(i), 2'b00};
        return (p == 7'h7F) ? 6'b000010 : 6'b000001;
    endfunction

    task automatic model_sample(input logic [3:0] a, input logic [7:0] s);
        logic [5:0] r;
        int d;
        d = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) d = i;
        r = ref_dec(s[6:0]);
        m_hex[d] = r[5:2];
        m_les[d] = r[1];
        m_bad[d] = r[0];
        m_pt[d] = ~s[7];
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back({|m_bad, m_bad, m_les, m_pt, m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
            m_seen = 4'h0;
        end
    endtask

    // A dwell is the run of cycles the bus holds one value; it is sampled once it lasts SETTLE cycles.
    task automatic step(input logic [3:0] a, input logic [7:0] s, input int len);
        int old;
        an = a;
        segment = s;
        repeat (len) @(negedge clk);
        if ({a, s} == m_prev) begin
            old = m_run;
            m_run += len;
        end else begin
            old = 0;
            m_run = len;
            m_prev = {a, s};
        end
        if ($onehot(~a) && old < SETTLE && m_run >= SETTLE) model_sample(a, s);
    endtask

    task automatic hold(input int n);
        step(an, segment, n);
    endtask

    task automatic scan(input logic [7:0] d0, d1, d2, d3, input int len);
        step(4'b1110, d0, len);
        step(4'b1101, d1, len);
        step(4'b1011, d2, len);
        step(4'b0111, d3, len);
    endtask

    task automatic check_frames(input string tag);
        logic [28:0] o, e;
        hold(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            last_exp = e;
            chk({tag, ".frame"}, 32'(o), 32'(e));
        end
        chk({tag, ".extra"}, obs_q.size(), 0);
        obs_q.delete();
        chk({tag, ".hold"}, {err, bad, les, point, hexs}, 32'(last_exp));
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        repeat (n) begin
            an = 4'($urandom);
            segment = 8'($urandom);
            @(negedge clk);
        end
        an = 4'hF;
        segment = 8'hFF;
        rst = 1'b0;
        chk("rst.outs", {frame_valid, err, bad, les, point, hexs}, 0);
        chk("rst.nofv", obs_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_hex[i] = '0;
        {m_pt, m_les, m_bad, m_seen} = '0;
        m_prev = {4'hF, 8'hFF};
        m_run = 0;
        last_exp = '0;
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] s;
        @(negedge clk);
        reset_dut(3);
        hold(6);
        chk("t1.idle", {frame_valid, err, bad, les, point, hexs}, 0);

        scan(8'h8E, 8'hA4, 8'h08, 8'hF9, 8);
        scan(8'h8E, 8'hA4, 8'h08, 8'hF9, 8);
        check_frames("t2");
        chk("t2.hexs", hexs, 16'h1A2F);
        chk("t2.point", point, 4'b0100);

        step(4'b1110, 8'hC0, 8);
        step(4'b1110, 8'h8E, 8);
        step(4'b1101, 8'hA4, 6);
        step(4'b1101, 8'hC0, 3);
        step(4'b1011, 8'h08, 8);
        step(4'b0111, 8'hF9, 8);
        check_frames("t3");
        chk("t3.hexs", hexs, 16'h1A2F);

        scan(8'hC0, 8'hFE, 8'h82, 8'hFF, 8);
        check_frames("t4");
        chk("t4.les", les, 4'b1000);
        chk("t4.bad", bad, 4'b0010);
        chk("t4.hexs", hexs, 16'h0600);
        chk("t4.err", err, 1);

        step(4'b1110, 8'h8E, 8);
        step(4'b1101, 8'hA4, 8);
        step(4'b1111, 8'hFF, 50);
        step(4'b1011, 8'h08, 8);
        step(4'b0111, 8'hF9, 8);
        check_frames("t5");
        chk("t5.hexs", hexs, 16'h1A2F);

        step(4'b1110, 8'h99, 8);
        step(4'b1101, 8'hB0, 8);
        step(4'b1011, 8'hC6, 8);
        hold(8);
        reset_dut(2);
        step(4'b0111, 8'h92, 8);
        check_frames("t6.partial");
        scan(8'h99, 8'hB0, 8'hC6, 8'h92, 8);
        check_frames("t6.full");
        chk("t6.hexs", hexs, 16'h5C34);

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 60; k++) begin
                a = ($urandom_range(0, 9) < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
                case ($urandom_range(0, 3))
                    0: s[6:0] = 7'h7F;
                    1: s[6:0] = 7'($urandom);
                    default: s[6:0] = TBL[$urandom_range(0, 15)];
                endcase
                s[7] = 1'($urandom);
                step(a, s, $urandom_range(1, 10));
            end
            check_frames("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
